// File: rtl/sprite_mover_pkg.sv
// Shared definitions for the sprite mover: direction encoding and controller states.
package sprite_mover_pkg;

  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirDown  = 2'd1;
  localparam logic [1:0] DirLeft  = 2'd2;
  localparam logic [1:0] DirRight = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StTurn,
    StTurnChk,
    StFwd,
    StFwdChk
  } state_e;

endpackage

// File: rtl/sprite_mover_step_calc.sv
// Combinational next-position candidate for one step in a given direction,
// with wrap or clamp at the inclusive bounds.
module sprite_mover_step_calc
  import sprite_mover_pkg::*;
#(
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 9,
  parameter int unsigned X_MIN = 0,
  parameter int unsigned X_MAX = 639,
  parameter int unsigned Y_MIN = 0,
  parameter int unsigned Y_MAX = 479,
  parameter int unsigned STEP  = 2,
  parameter int unsigned WRAP  = 0
) (
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  input  logic [1:0]     dir_i,
  output logic [X_W-1:0] cand_x_o,
  output logic [Y_W-1:0] cand_y_o,
  output logic           same_o
);

  localparam bit          Wrap  = (WRAP != 0);
  localparam logic [X_W:0] XMin  = (X_W+1)'(X_MIN);
  localparam logic [X_W:0] XMax  = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] XStep = (X_W+1)'(STEP);
  localparam logic [Y_W:0] YMin  = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W:0] YMax  = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] YStep = (Y_W+1)'(STEP);

  logic [X_W:0] xe, x_inc, cx;
  logic [Y_W:0] ye, y_inc, cy;

  always_comb begin
    xe    = {1'b0, x_i};
    ye    = {1'b0, y_i};
    x_inc = xe + XStep;
    y_inc = ye + YStep;
    cx    = xe;
    cy    = ye;
    unique case (dir_i)
      DirRight: begin
        if (x_inc > XMax) cx = Wrap ? XMin + (x_inc - XMax) - 1'b1 : XMax;
        else              cx = x_inc;
      end
      DirLeft: begin
        // Undershoot measured from MIN mirrors the overshoot used on the right edge.
        if (xe < XMin + XStep) cx = Wrap ? XMax - (XMin + XStep - xe) + 1'b1 : XMin;
        else                   cx = xe - XStep;
      end
      DirDown: begin
        if (y_inc > YMax) cy = Wrap ? YMin + (y_inc - YMax) - 1'b1 : YMax;
        else              cy = y_inc;
      end
      DirUp: begin
        if (ye < YMin + YStep) cy = Wrap ? YMax - (YMin + YStep - ye) + 1'b1 : YMin;
        else                   cy = ye - YStep;
      end
      default: ;
    endcase
  end

  assign cand_x_o = cx[X_W-1:0];
  assign cand_y_o = cy[Y_W-1:0];
  // A clamped step that goes nowhere counts as hitting a wall.
  assign same_o   = !Wrap && (cx == xe) && (cy == ye);

endmodule

// File: rtl/sprite_mover.sv
// Tick-paced sprite controller: accepts direction commands, probes an external
// wall map for each candidate step and commits the move when the way is clear.
module sprite_mover
  import sprite_mover_pkg::*;
#(
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 639,
  parameter int unsigned Y_MIN    = 0,
  parameter int unsigned Y_MAX    = 479,
  parameter int unsigned X_INIT   = 30,
  parameter int unsigned Y_INIT   = 146,
  parameter int unsigned STEP     = 2,
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned WRAP     = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           cmd_valid,
  input  logic [1:0]     cmd_dir,
  input  logic           cmd_stop,
  output logic [X_W-1:0] probe_x,
  output logic [Y_W-1:0] probe_y,
  output logic           probe_valid,
  input  logic           wall_hit,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     dir,
  output logic           moving,
  output logic           blocked,
  output logic           moved
);

  localparam int unsigned     CntW   = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);
  localparam logic [X_W-1:0]  XInit  = X_W'(X_INIT);
  localparam logic [Y_W-1:0]  YInit  = Y_W'(Y_INIT);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]  x_q, x_d, cand_x_q, cand_x_d, step_x;
  logic [Y_W-1:0]  y_q, y_d, cand_y_q, cand_y_d, step_y;
  logic [1:0]      dir_q, dir_d, pend_dir_q, pend_dir_d, cand_dir_q, cand_dir_d, step_dir;
  logic            moving_q, moving_d, blocked_q, blocked_d, moved_q, moved_d;
  logic            pend_valid_q, pend_valid_d, cand_same_q, cand_same_d, step_same;
  logic            tick, hit;

  assign tick     = en && (cnt_q == CntMax);
  assign step_dir = (state_q == StTurn) ? pend_dir_q : dir_q;
  assign hit      = wall_hit || cand_same_q;

  sprite_mover_step_calc #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .X_MIN (X_MIN),
    .X_MAX (X_MAX),
    .Y_MIN (Y_MIN),
    .Y_MAX (Y_MAX),
    .STEP  (STEP),
    .WRAP  (WRAP)
  ) u_step_calc (
    .x_i      (x_q),
    .y_i      (y_q),
    .dir_i    (step_dir),
    .cand_x_o (step_x),
    .cand_y_o (step_y),
    .same_o   (step_same)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    moving_d     = moving_q;
    blocked_d    = blocked_q;
    moved_d      = 1'b0;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    cand_dir_d   = cand_dir_q;
    cand_same_d  = cand_same_q;

    if (en) cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;

    if (cmd_valid) begin
      pend_dir_d   = cmd_dir;
      pend_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          if (pend_valid_q)  state_d = StTurn;
          else if (moving_q) state_d = StFwd;
        end
      end
      StTurn, StFwd: begin
        // Hold the probed candidate so the check uses exactly what the map saw.
        cand_x_d    = step_x;
        cand_y_d    = step_y;
        cand_dir_d  = step_dir;
        cand_same_d = step_same;
        state_d     = (state_q == StTurn) ? StTurnChk : StFwdChk;
      end
      StTurnChk: begin
        if (!hit) begin
          x_d          = cand_x_q;
          y_d          = cand_y_q;
          dir_d        = cand_dir_q;
          moving_d     = 1'b1;
          blocked_d    = 1'b0;
          moved_d      = 1'b1;
          pend_valid_d = cmd_valid;
          state_d      = StIdle;
        end else begin
          state_d = moving_q ? StFwd : StIdle;
        end
      end
      StFwdChk: begin
        if (!hit) begin
          x_d       = cand_x_q;
          y_d       = cand_y_q;
          blocked_d = 1'b0;
          moved_d   = 1'b1;
        end else begin
          moving_d  = 1'b0;
          blocked_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Stop aborts any in-flight step without committing it.
    if (cmd_stop) begin
      state_d      = StIdle;
      moving_d     = 1'b0;
      pend_valid_d = 1'b0;
      x_d          = x_q;
      y_d          = y_q;
      dir_d        = dir_q;
      blocked_d    = blocked_q;
      moved_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      x_q          <= XInit;
      y_q          <= YInit;
      dir_q        <= DirRight;
      moving_q     <= 1'b0;
      blocked_q    <= 1'b0;
      moved_q      <= 1'b0;
      pend_dir_q   <= DirRight;
      pend_valid_q <= 1'b0;
      cand_x_q     <= XInit;
      cand_y_q     <= YInit;
      cand_dir_q   <= DirRight;
      cand_same_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      moving_q     <= moving_d;
      blocked_q    <= blocked_d;
      moved_q      <= moved_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      cand_dir_q   <= cand_dir_d;
      cand_same_q  <= cand_same_d;
    end
  end

  assign probe_valid = (state_q == StTurn) || (state_q == StFwd);
  assign probe_x     = probe_valid ? step_x : x_q;
  assign probe_y     = probe_valid ? step_y : y_q;
  assign x           = x_q;
  assign y           = y_q;
  assign dir         = dir_q;
  assign moving      = moving_q;
  assign blocked     = blocked_q;
  assign moved       = moved_q;

endmodule
